// File: rtl/nolinear_out_packer.sv
// Output packer: buffers DATA_NUM-element result vectors in a DEPTH-entry FIFO and
// streams each one out as BEATS valid/ready beats of LANES elements.
module nolinear_out_packer #(
    parameter int unsigned FIX_POINT_WIDTH = 16,
    parameter int unsigned DATA_NUM        = 16,
    parameter int unsigned LANES           = 4,
    parameter int unsigned DEPTH           = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] in_data,
    input  logic [1:0]                          in_mode,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LANES*FIX_POINT_WIDTH-1:0]    out_data,
    output logic [1:0]                          out_mode,
    output logic                                out_first,
    output logic                                out_last,
    output logic [$clog2(DEPTH):0]              level
);

    localparam int unsigned BEATS  = DATA_NUM / LANES;
    localparam int unsigned VEC_W  = DATA_NUM * FIX_POINT_WIDTH;
    localparam int unsigned BEAT_W = LANES * FIX_POINT_WIDTH;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [VEC_W-1:0] r_mem      [DEPTH];
    logic [1:0]       r_mode_mem [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_beat;
    logic [LVL_W-1:0] r_level;

    logic             w_push;
    logic             w_xfer;
    logic             w_last;
    logic             w_pop;
    logic [VEC_W-1:0] w_head;
    logic [31:0]      w_beat_off;

    assign in_ready   = !rst && (r_level != LVL_W'(DEPTH));
    assign out_valid  = (r_level != '0);
    assign w_push     = in_valid && in_ready;
    assign w_xfer     = out_valid && out_ready;
    assign w_last     = (r_beat == CNT_W'(BEATS - 1));
    assign w_pop      = w_xfer && w_last;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_beat_off = 32'(r_beat) * BEAT_W;
    assign out_data   = w_head[w_beat_off +: BEAT_W];
    assign out_mode   = r_mode_mem[r_rd_ptr];
    assign out_first  = (r_beat == '0);
    assign out_last   = w_last;
    assign level      = r_level;

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]      <= in_data;
            r_mode_mem[r_wr_ptr] <= in_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_beat   <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_xfer) begin
                if (w_last) begin
                    r_beat   <= '0;
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nolinear_out_packer.sv
// Directed bench for nolinear_out_packer with a queue model checking every cycle.
module tb_nolinear_out_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [1:0]   out_mode;
    logic         out_first;
    logic         out_last;
    logic [2:0]   level;

    int n_checks = 0;
    int n_errors = 0;

    logic [255:0] q_data [$];
    logic [1:0]   q_mode [$];
    int           m_beat = 0;

    nolinear_out_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_first (out_first),
        .out_last  (out_last),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mkvec(input logic [15:0] base);
        logic [255:0] v;
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = base + 16'(k);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs against the queue model after each edge.
    task automatic check_model(input string tag);
        check({tag, ".level"}, 64'(level), 64'(q_data.size()));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(q_data.size() != 4));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(q_data.size() != 0));
        if (q_data.size() != 0) begin
            check({tag, ".out_data"}, out_data, q_data[0][m_beat*64 +: 64]);
            check({tag, ".out_mode"}, 64'(out_mode), 64'(q_mode[0]));
            check({tag, ".out_first"}, 64'(out_first), 64'(m_beat == 0));
            check({tag, ".out_last"}, 64'(out_last), 64'(m_beat == 3));
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [255:0] d,
                        input logic [1:0] m, input logic r, output logic pushed);
        logic do_push;
        logic do_xfer;
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = r;
        do_push   = v && (q_data.size() != 4);
        do_xfer   = r && (q_data.size() != 0);
        tick();
        if (do_xfer) begin
            if (m_beat == 3) begin
                m_beat = 0;
                void'(q_data.pop_front());
                void'(q_mode.pop_front());
            end else begin
                m_beat++;
            end
        end
        if (do_push) begin
            q_data.push_back(d);
            q_mode.push_back(m);
        end
        pushed = do_push;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        q_data.delete();
        q_mode.delete();
        m_beat = 0;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.level", 64'(level), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst.in_ready_after", 64'(in_ready), 64'd1);
    endtask

    task automatic drain(input string tag);
        logic p;
        for (int i = 0; i < 64 && q_data.size() != 0; i++) step(tag, 1'b0, '0, 2'b00, 1'b1, p);
        check({tag, ".drained"}, 64'(q_data.size()), 64'd0);
    endtask

    logic         p;
    logic [255:0] rv [16];
    logic [1:0]   rm [16];
    logic [1:0]   exp_modes [3];
    int           idx;
    int           mode_idx;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        tick();
        do_reset();

        // 1) single vector
        step("s1.push", 1'b1, mkvec(16'h0100), 2'b01, 1'b1, p);
        check("s1.beat0", out_data, 64'h0103_0102_0101_0100);
        check("s1.first0", 64'(out_first), 64'd1);
        check("s1.mode", 64'(out_mode), 64'd1);
        check("s1.level1", 64'(level), 64'd1);
        step("s1.b1", 1'b0, '0, 2'b00, 1'b1, p);
        check("s1.beat1", out_data, 64'h0107_0106_0105_0104);
        step("s1.b2", 1'b0, '0, 2'b00, 1'b1, p);
        step("s1.b3", 1'b0, '0, 2'b00, 1'b1, p);
        check("s1.beat3", out_data, 64'h010F_010E_010D_010C);
        check("s1.last3", 64'(out_last), 64'd1);
        step("s1.end", 1'b0, '0, 2'b00, 1'b1, p);
        check("s1.level0", 64'(level), 64'd0);
        check("s1.valid0", 64'(out_valid), 64'd0);

        // 2) fill with out_ready low; fifth vector held off
        for (int i = 0; i < 4; i++) step("s2.fill", 1'b1, mkvec(16'h1000 + 16'(i*256)), 2'b10, 1'b0, p);
        check("s2.level4", 64'(level), 64'd4);
        check("s2.full_ready", 64'(in_ready), 64'd0);
        step("s2.held", 1'b1, mkvec(16'h1400), 2'b10, 1'b0, p);
        check("s2.held_push", 64'(p), 64'd0);
        for (int i = 0; i < 4; i++) step("s2.pop", 1'b1, mkvec(16'h1400), 2'b10, 1'b1, p);
        check("s2.ready_back", 64'(in_ready), 64'd1);
        check("s2.level3", 64'(level), 64'd3);
        step("s2.push5", 1'b1, mkvec(16'h1400), 2'b10, 1'b1, p);
        check("s2.push5_ok", 64'(p), 64'd1);
        drain("s2.drain");

        // 3) backpressure mid-vector
        step("s3.push", 1'b1, mkvec(16'h0100), 2'b01, 1'b0, p);
        step("s3.r1", 1'b0, '0, 2'b00, 1'b1, p);
        check("s3.beat1", out_data, 64'h0107_0106_0105_0104);
        for (int i = 0; i < 2; i++) begin
            step("s3.stall", 1'b0, '0, 2'b00, 1'b0, p);
            check("s3.frozen_data", out_data, 64'h0107_0106_0105_0104);
            check("s3.frozen_last", 64'(out_last), 64'd0);
        end
        step("s3.r2", 1'b0, '0, 2'b00, 1'b1, p);
        check("s3.beat2", out_data, 64'h010B_010A_0109_0108);
        step("s3.r3", 1'b0, '0, 2'b00, 1'b1, p);
        check("s3.beat3", out_data, 64'h010F_010E_010D_010C);
        check("s3.last", 64'(out_last), 64'd1);
        drain("s3.drain");

        // 4) simultaneous push/pop at level 2, then a random stream
        step("s4.a", 1'b1, mkvec(16'h2000), 2'b11, 1'b0, p);
        step("s4.b", 1'b1, mkvec(16'h2100), 2'b00, 1'b0, p);
        for (int i = 0; i < 3; i++) step("s4.beats", 1'b0, '0, 2'b00, 1'b1, p);
        check("s4.pre_last", 64'(out_last), 64'd1);
        step("s4.pushpop", 1'b1, mkvec(16'h2200), 2'b01, 1'b1, p);
        check("s4.level_stays2", 64'(level), 64'd2);
        drain("s4.drain");
        for (int i = 0; i < 16; i++) begin
            for (int w = 0; w < 8; w++) rv[i][w*32 +: 32] = $urandom;
            rm[i] = 2'($urandom_range(0, 3));
        end
        idx = 0;
        for (int c = 0; c < 3000 && (idx < 16 || q_data.size() != 0); c++) begin
            step("s4.rand", (idx < 16) && ($urandom_range(0, 1) == 1), rv[idx % 16], rm[idx % 16],
                 $urandom_range(0, 3) != 0, p);
            if (p) idx++;
        end
        check("s4.rand_done", 64'((idx == 16) && (q_data.size() == 0)), 64'd1);

        // 5) reset mid-vector at level 3
        for (int i = 0; i < 3; i++) step("s5.fill", 1'b1, mkvec(16'h3000 + 16'(i*256)), 2'b01, 1'b0, p);
        step("s5.b0", 1'b0, '0, 2'b00, 1'b1, p);
        step("s5.b1", 1'b0, '0, 2'b00, 1'b1, p);
        check("s5.level3", 64'(level), 64'd3);
        do_reset();
        step("s5.push", 1'b1, mkvec(16'h0500), 2'b11, 1'b0, p);
        check("s5.first", 64'(out_first), 64'd1);
        check("s5.beat0", out_data, 64'h0503_0502_0501_0500);
        drain("s5.drain");

        // 6) mode tags change only at vector boundaries
        exp_modes[0] = 2'b00;
        exp_modes[1] = 2'b10;
        exp_modes[2] = 2'b11;
        step("s6.p0", 1'b1, mkvec(16'h6000), 2'b00, 1'b1, p);
        check("s6.mode0", 64'(out_mode), 64'd0);
        step("s6.p1", 1'b1, mkvec(16'h6100), 2'b10, 1'b1, p);
        step("s6.p2", 1'b1, mkvec(16'h6200), 2'b11, 1'b1, p);
        mode_idx = 1;
        for (int i = 0; i < 20 && q_data.size() != 0; i++) begin
            step("s6.drain", 1'b0, '0, 2'b00, 1'b1, p);
            if (out_valid && out_first && mode_idx < 3) begin
                check("s6.mode_seq", 64'(out_mode), 64'(exp_modes[mode_idx]));
                mode_idx++;
            end
        end
        check("s6.all_modes", 64'(mode_idx), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
